decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised instruction-decode stage that replaces the single-entry decode register with a DEPTH-entry instruction queue between fetch and execute. Each entry holds the fetched instruction, PC, pre-extracted immediate, upstream exception/mcause and branch-prediction bit. The head entry is decoded combinationally into register indices, function codes, CSR controls and decode-time exceptions (illegal instruction, ebreak, ecall). Flush empties the queue in one cycle; stall freezes the head.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- XLEN, 32, width of PC and immediate.
- PRED_EN, 1, when 0 the predict bit is not stored and o_predict is tied 0.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_valid  in  1  fetch presents an instruction.
- o_ready  out  1  queue can accept; equals !full.
- i_inst  in  32  instruction word.
- i_pc, i_imm  in  XLEN  PC and immediate.
- i_exception  in  1  upstream (fetch) exception.
- i_mcause  in  4  upstream cause.
- i_predict  in  1  BTB predicted taken.
- o_valid  out  1  head entry valid; equals !empty.
- i_ready  in  1  execute accepts the head.
- i_stall  in  1  hazard hold; blocks dequeue.
- i_flush  in  1  redirect; discards all entries.
- o_op  out  7  inst[6:0].
- o_func  out  3  inst[14:12].
- o_reg_rd, o_reg_rs1, o_reg_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20].
- o_reg_wen  out  1  destination write enable.
- o_imm, o_pc  out  XLEN  head entry fields.
- o_csr  out  12  inst[31:20].
- o_csr_t  out  2  bit0 = CSR class and func!=0; bit1 = mret.
- o_mret  out  1  inst == 0x30200073.
- o_exception  out  1  head raises an exception.
- o_mcause  out  4  cause for o_exception.
- o_predict  out  1  head prediction bit.
- o_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: circular buffer, read pointer rp, write pointer wp (each $clog2(DEPTH) bits, wrap DEPTH-1 -> 0), count register.
- enq = i_valid & o_ready & !i_flush; writes entry at wp, wp++.
- deq = o_valid & i_ready & !i_stall & !i_flush; rp++.
- count: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Full (count==DEPTH): o_ready=0, i_valid ignored; no enqueue-through-dequeue bypass when full.
- Empty: o_valid=0; enqueue bypass to the output is not provided.
- Flush: rp, wp, count <- 0 next cycle; any same-cycle enq and deq are discarded. Flush has priority over stall.
- Class decode on head op[6:2]: I=00100, R=01100, L=00000, S=01000, JAL=11011, JALR=11001, AUIPC=00101, LUI=01101, B=11000, CSR=11100, FENCE=00011.
- illegal = none of the classes; breakpoint = inst==0x00100073; ecall = inst==0x00000073.
- Local cause: illegal -> 2, breakpoint -> 3, ecall -> 11.
- o_exception = o_valid & (head.exception | illegal | breakpoint | ecall).
- o_mcause = head.exception ? head.mcause : local cause. Upstream exceptions take priority.
- o_reg_wen = o_valid & (I|R|L|JAL|JALR|AUIPC|LUI) & !o_exception.
- o_csr_t and o_mret are gated by o_valid.
- When empty, all field outputs carry the stale entry at rp. Consumers qualify them with o_valid.

## Timing
- Reset: o_valid=0, o_ready=1, o_count=0, o_exception=0, o_reg_wen=0, o_csr_t=0, o_mret=0, pointers 0. Stored data is not reset.
- Latency: enq at edge t makes the entry visible at the head after edge t (o_valid=1 in cycle t+1) when the queue was empty.
- Throughput: one enqueue and one dequeue per cycle sustained.
- o_ready and o_valid are derived from registered count only, with no combinational path from i_ready/i_valid.
- Reset asserted mid-operation behaves as flush plus output reset. Reset overrides flush.

## Test plan
- Reset, then push 4 instructions (0x00500093 addi, 0x002081b3 add, 0x0000a103 lw, 0x00112023 sw), i_ready=0 -> o_count=4, o_ready=0, 5th i_valid ignored; release i_ready -> heads dequeue in order, o_reg_wen = 1,1,1,0.
- Streaming with i_valid=i_ready=1 for 20 cycles, PCs 0x80000000+4n -> one output per cycle, no gaps, PCs in order across pointer wrap.
- Full queue plus i_flush and i_valid together -> next cycle o_count=0, o_valid=0, o_ready=1; the flush-cycle instruction is dropped.
- Head 0x00000073 -> o_exception=1, o_mcause=11; 0x00100073 -> 3; 0x0000007f -> 2; head with i_exception=1 and i_mcause=1 carrying 0x00000073 -> o_mcause=1.
- i_stall=1 with a valid head and i_ready=1 for 3 cycles -> o_count constant, head fields stable; deasserting the stall dequeues on the next edge.
- CSR 0x30529073 -> o_csr=0x305, o_csr_t=01; 0x30200073 -> o_mret=1, o_csr_t=10, o_reg_wen=0.

Source files
------------

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - DEPTH-entry instruction queue with combinational head decode
module decode_queue #(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int PRED_EN = 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [31:0]                i_inst,
  input  logic [XLEN-1:0]            i_pc,
  input  logic [XLEN-1:0]            i_imm,
  input  logic                       i_exception,
  input  logic [3:0]                 i_mcause,
  input  logic                       i_predict,
  output logic                       o_valid,
  input  logic                       i_ready,
  input  logic                       i_stall,
  input  logic                       i_flush,
  output logic [6:0]                 o_op,
  output logic [2:0]                 o_func,
  output logic [4:0]                 o_reg_rd,
  output logic [4:0]                 o_reg_rs1,
  output logic [4:0]                 o_reg_rs2,
  output logic                       o_reg_wen,
  output logic [XLEN-1:0]            o_imm,
  output logic [XLEN-1:0]            o_pc,
  output logic [11:0]                o_csr,
  output logic [1:0]                 o_csr_t,
  output logic                       o_mret,
  output logic                       o_exception,
  output logic [3:0]                 o_mcause,
  output logic                       o_predict,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     inst_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] imm_mem   [DEPTH];
  logic            exc_mem   [DEPTH];
  logic [3:0]      cause_mem [DEPTH];

  logic [AW-1:0] rp, wp;
  logic [CW-1:0] count;
  logic          enq, deq;

  // Handshake flags come from the registered count only.
  assign o_ready = (count != CW'(DEPTH));
  assign o_valid = (count != '0);
  assign o_count = count;
  assign enq     = i_valid & o_ready & ~i_flush;
  assign deq     = o_valid & i_ready & ~i_stall & ~i_flush;

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (enq) wp <= wp + AW'(1);
      if (deq) rp <= rp + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; data itself is never reset.
  always_ff @(posedge i_clock) begin
    if (enq && !i_reset) begin
      inst_mem[wp]  <= i_inst;
      pc_mem[wp]    <= i_pc;
      imm_mem[wp]   <= i_imm;
      exc_mem[wp]   <= i_exception;
      cause_mem[wp] <= i_mcause;
    end
  end

  logic head_pred;
  generate
    if (PRED_EN != 0) begin : g_pred
      logic pred_mem [DEPTH];
      // Prediction bit storage, present only when prediction is enabled.
      always_ff @(posedge i_clock) begin
        if (enq && !i_reset) pred_mem[wp] <= i_predict;
      end
      assign head_pred = pred_mem[rp];
    end else begin : g_no_pred
      assign head_pred = 1'b0;
    end
  endgenerate

  logic [31:0] head_inst;
  logic        head_exc;
  logic [3:0]  head_cause;
  assign head_inst  = inst_mem[rp];
  assign head_exc   = exc_mem[rp];
  assign head_cause = cause_mem[rp];

  assign o_op      = head_inst[6:0];
  assign o_func    = head_inst[14:12];
  assign o_reg_rd  = head_inst[11:7];
  assign o_reg_rs1 = head_inst[19:15];
  assign o_reg_rs2 = head_inst[24:20];
  assign o_csr     = head_inst[31:20];
  assign o_imm     = imm_mem[rp];
  assign o_pc      = pc_mem[rp];
  assign o_predict = o_valid & head_pred;

  logic writes_rd, is_csr, illegal, brk, ecall, mret;
  logic [3:0] local_cause;

  // Classify the head instruction and derive decode-time exceptions.
  always_comb begin
    writes_rd   = 1'b0;
    is_csr      = 1'b0;
    illegal     = 1'b0;
    local_cause = 4'd0;
    case (head_inst[6:2])
      5'b00100, 5'b01100, 5'b00000, 5'b11011,
      5'b11001, 5'b00101, 5'b01101:            writes_rd = 1'b1;
      5'b01000, 5'b11000, 5'b00011:            writes_rd = 1'b0;
      5'b11100:                                is_csr    = 1'b1;
      default:                                 illegal   = 1'b1;
    endcase
    brk   = (head_inst == 32'h0010_0073);
    ecall = (head_inst == 32'h0000_0073);
    mret  = (head_inst == 32'h3020_0073);
    if (illegal)    local_cause = 4'd2;
    else if (brk)   local_cause = 4'd3;
    else if (ecall) local_cause = 4'd11;
  end

  assign o_exception = o_valid & (head_exc | illegal | brk | ecall);
  assign o_mcause    = head_exc ? head_cause : local_cause;
  assign o_reg_wen   = o_valid & writes_rd & ~o_exception;
  assign o_mret      = o_valid & mret;
  assign o_csr_t     = {o_valid & mret, o_valid & is_csr & (o_func != 3'd0)};
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard bench for decode_queue
module tb_decode_queue;
  logic        i_clock, i_reset, i_valid, i_exception, i_predict, i_ready, i_stall, i_flush;
  logic [31:0] i_inst, i_pc, i_imm;
  logic [3:0]  i_mcause;
  logic        o_ready, o_valid, o_reg_wen, o_mret, o_exception, o_predict;
  logic [6:0]  o_op;
  logic [2:0]  o_func;
  logic [4:0]  o_reg_rd, o_reg_rs1, o_reg_rs2;
  logic [31:0] o_imm, o_pc;
  logic [11:0] o_csr;
  logic [1:0]  o_csr_t;
  logic [3:0]  o_mcause;
  logic [2:0]  o_count;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        wen;
    logic        exc;
    logic [3:0]  cause;
    logic [1:0]  csr_t;
    logic        mret;
  } exp_t;

  exp_t sb[$];

  decode_queue #(.DEPTH(4), .XLEN(32), .PRED_EN(1)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_imm(i_imm), .i_exception(i_exception),
    .i_mcause(i_mcause), .i_predict(i_predict), .o_valid(o_valid), .i_ready(i_ready),
    .i_stall(i_stall), .i_flush(i_flush), .o_op(o_op), .o_func(o_func),
    .o_reg_rd(o_reg_rd), .o_reg_rs1(o_reg_rs1), .o_reg_rs2(o_reg_rs2),
    .o_reg_wen(o_reg_wen), .o_imm(o_imm), .o_pc(o_pc), .o_csr(o_csr),
    .o_csr_t(o_csr_t), .o_mret(o_mret), .o_exception(o_exception),
    .o_mcause(o_mcause), .o_predict(o_predict), .o_count(o_count)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic w, input logic x, input logic [3:0] c,
                              input logic [1:0] t, input logic m);
    exp_t r;
    r = '{default: '0};
    r.wen = w; r.exc = x; r.cause = c; r.csr_t = t; r.mret = m;
    return r;
  endfunction

  // One cycle: drive inputs after a falling edge, check the head, update the model.
  task automatic tick(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic uexc, input logic [3:0] ucause, input logic rdy,
                      input logic stall, input logic flush, input logic rst, input exp_t e);
    exp_t h;
    exp_t n;
    int   sz;
    i_valid = v; i_inst = inst; i_pc = pc; i_imm = pc ^ 32'h5a5a_0000;
    i_exception = uexc; i_mcause = ucause; i_predict = pc[2];
    i_ready = rdy; i_stall = stall; i_flush = flush; i_reset = rst;
    #1;
    sz = sb.size();
    check("count", 64'(o_count), 64'(sz));
    check("ready", 64'(o_ready), 64'(sz != 4));
    check("valid", 64'(o_valid), 64'(sz != 0));
    if (sz != 0) begin
      h = sb[0];
      check("pc",    64'(o_pc),        64'(h.pc));
      check("imm",   64'(o_imm),       64'(h.imm));
      check("op",    64'(o_op),        64'(h.inst[6:0]));
      check("func",  64'(o_func),      64'(h.inst[14:12]));
      check("rd",    64'(o_reg_rd),    64'(h.inst[11:7]));
      check("rs1",   64'(o_reg_rs1),   64'(h.inst[19:15]));
      check("rs2",   64'(o_reg_rs2),   64'(h.inst[24:20]));
      check("csr",   64'(o_csr),       64'(h.inst[31:20]));
      check("pred",  64'(o_predict),   64'(h.pred));
      check("wen",   64'(o_reg_wen),   64'(h.wen));
      check("exc",   64'(o_exception), 64'(h.exc));
      check("csr_t", 64'(o_csr_t),     64'(h.csr_t));
      check("mret",  64'(o_mret),      64'(h.mret));
      if (h.exc) check("mcause", 64'(o_mcause), 64'(h.cause));
      if (rdy && !stall && !flush) void'(sb.pop_front());
    end
    if (rst || flush) sb.delete();
    else if (v && sz != 4) begin
      n = e;
      n.inst = inst; n.pc = pc; n.imm = pc ^ 32'h5a5a_0000; n.pred = pc[2];
      sb.push_back(n);
    end
    @(negedge i_clock);
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    tick(1'b1, inst, pc, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, rdy, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
  endtask

  initial begin
    i_valid = 0; i_inst = 0; i_pc = 0; i_imm = 0; i_exception = 0; i_mcause = 0;
    i_predict = 0; i_ready = 0; i_stall = 0; i_flush = 0; i_reset = 1;
    repeat (3) @(negedge i_clock);
    i_reset = 0;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_exc",   64'(o_exception), 64'd0);
    check("rst_wen",   64'(o_reg_wen), 64'd0);
    check("rst_csr_t", 64'(o_csr_t), 64'd0);
    check("rst_mret",  64'(o_mret), 64'd0);
    @(negedge i_clock);

    // Fill, ignore a fifth push, then drain in order.
    push(32'h0050_0093, 32'h100, mk(1, 0, 0, 0, 0));
    push(32'h0020_81b3, 32'h104, mk(1, 0, 0, 0, 0));
    push(32'h0000_a103, 32'h108, mk(1, 0, 0, 0, 0));
    push(32'h0011_2023, 32'h10c, mk(0, 0, 0, 0, 0));
    push(32'h0050_0093, 32'h999, mk(1, 0, 0, 0, 0));
    repeat (5) idle(1'b1);

    // Streaming across pointer wrap.
    for (int n = 0; n < 20; n++)
      tick(1'b1, 32'h0050_0093, 32'h8000_0000 + 32'(4 * n), 1'b0, 4'd0, 1'b1,
           1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0));
    repeat (2) idle(1'b1);

    // Flush a full queue together with a new instruction.
    for (int n = 0; n < 4; n++) push(32'h0050_0093, 32'h200 + 32'(4 * n), mk(1, 0, 0, 0, 0));
    tick(1'b1, 32'h0020_81b3, 32'h300, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0));
    idle(1'b1);

    // Exception causes and upstream priority.
    push(32'h0000_0073, 32'h400, mk(0, 1, 4'd11, 2'b00, 0));
    push(32'h0010_0073, 32'h404, mk(0, 1, 4'd3, 2'b00, 0));
    push(32'h0000_007f, 32'h408, mk(0, 1, 4'd2, 2'b00, 0));
    tick(1'b1, 32'h0000_0073, 32'h40c, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 1, 4'd1, 2'b00, 0));
    repeat (5) idle(1'b1);

    // Stall holds the head for three cycles with i_ready high.
    push(32'h0050_0093, 32'h500, mk(1, 0, 0, 0, 0));
    push(32'h0020_81b3, 32'h504, mk(1, 0, 0, 0, 0));
    repeat (3) tick(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    repeat (3) idle(1'b1);

    // CSR access and mret.
    push(32'h3052_9073, 32'h600, mk(0, 0, 0, 2'b01, 0));
    push(32'h3020_0073, 32'h604, mk(0, 0, 0, 2'b10, 1));
    repeat (3) idle(1'b1);

    // Reset in the middle of operation empties the queue.
    push(32'h0050_0093, 32'h700, mk(1, 0, 0, 0, 0));
    push(32'h0050_0093, 32'h704, mk(1, 0, 0, 0, 0));
    tick(1'b1, 32'h0050_0093, 32'h708, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0));
    repeat (2) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
